// File: rtl/uart_rx_oversampled_if.sv
// Host-side handshake bundle of the oversampling UART receiver.
// master: receiver side, slave: host logic that pops words.
interface uart_rx_oversampled_if #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4
);
    logic [DATA_BITS-1:0]              data_out;
    logic                              parity_error;
    logic                              framing_error;
    logic                              data_valid;
    logic                              data_ack;
    logic                              overrun;
    logic                              busy;
    logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count;

    modport master (
        output data_out, parity_error, framing_error, data_valid,
               overrun, busy, fifo_count,
        input  data_ack
    );

    modport slave (
        input  data_out, parity_error, framing_error, data_valid,
               overrun, busy, fifo_count,
        output data_ack
    );
endinterface

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: 2-flop synchroniser, tick divider, 3-sample
// majority vote, configurable frame format and a small status-tagged FIFO.
module uart_rx_oversampled #(
    parameter int unsigned CLOCK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic clk,
    input  logic Rst,
    input  logic enable,
    input  logic Rx,
    uart_rx_oversampled_if.master host
);
    localparam int unsigned TICK_RAW = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
    localparam int unsigned DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SAMP_W   = $clog2(OVERSAMPLE);
    localparam int unsigned MID      = OVERSAMPLE / 2;
    localparam int unsigned BIT_W    = 4;
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned WORD_W   = DATA_BITS + 2;
    localparam logic        PAR_ODD  = (PARITY_MODE == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t state, state_n;

    logic                 rx_meta, rx_s, rx_prev, fall;
    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;
    logic [SAMP_W-1:0]    samp_cnt, samp_next;
    logic                 smp_a, smp_b, bit_val, decide;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 perr, ferr;
    logic                 start_det, push, shift_en;

    logic [WORD_W-1:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 overrun_r, pop, full, push_ok;
    logic [WORD_W-1:0]    head;

    assign fall      = rx_prev & ~rx_s;
    assign tick      = (div_cnt == DIV_W'(TICK_DIV - 1));
    assign samp_next = (samp_cnt == SAMP_W'(OVERSAMPLE - 1)) ? '0 : samp_cnt + SAMP_W'(1);
    // Sample index is the counter value reached by the current tick, so the
    // decision lands (M+1) ticks after the start edge.
    assign decide    = tick && (samp_next == SAMP_W'(MID + 1));
    assign bit_val   = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);

    always_comb begin
        state_n   = state;
        start_det = 1'b0;
        push      = 1'b0;
        shift_en  = 1'b0;
        case (state)
            IDLE: if (enable && fall) begin
                state_n   = START;
                start_det = 1'b1;
            end
            START: if (decide) state_n = bit_val ? IDLE : DATA;
            DATA: if (decide) begin
                shift_en = 1'b1;
                if (bit_cnt == BIT_W'(DATA_BITS - 1))
                    state_n = (PARITY_MODE != 0) ? PARITY : STOP;
            end
            PARITY: if (decide) state_n = STOP;
            STOP: if (decide && bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                push    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (!enable) begin
            state_n   = IDLE;
            start_det = 1'b0;
            push      = 1'b0;
            shift_en  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            div_cnt   <= '0;
            samp_cnt  <= '0;
            smp_a     <= 1'b1;
            smp_b     <= 1'b1;
            bit_cnt   <= '0;
            shift_reg <= '0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
        end else begin
            state   <= state_n;
            rx_meta <= Rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            if (start_det) begin
                div_cnt  <= '0;
                samp_cnt <= '0;
                bit_cnt  <= '0;
                perr     <= 1'b0;
                ferr     <= 1'b0;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                if (tick) begin
                    samp_cnt <= samp_next;
                    if (samp_next == SAMP_W'(MID - 1)) smp_a <= rx_s;
                    if (samp_next == SAMP_W'(MID))     smp_b <= rx_s;
                end
                if (shift_en)
                    shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
                if (state == PARITY && decide)
                    perr <= bit_val ^ (^shift_reg) ^ PAR_ODD;
                if (state == STOP && decide)
                    ferr <= ferr | ~bit_val;
                if (decide && (state == DATA || state == STOP))
                    bit_cnt <= (state_n == state) ? bit_cnt + BIT_W'(1) : '0;
            end
        end
    end

    assign pop     = host.data_ack && (count != '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun_r <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= {perr, ferr | ~bit_val, shift_reg};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (pop)
                overrun_r <= 1'b0;
            else if (push && full)
                overrun_r <= 1'b1;
        end
    end

    assign head               = mem[rd_ptr];
    assign host.data_out      = head[DATA_BITS-1:0];
    assign host.framing_error = head[DATA_BITS];
    assign host.parity_error  = head[DATA_BITS+1];
    assign host.data_valid    = (count != '0);
    assign host.overrun       = overrun_r;
    assign host.busy          = (state != IDLE);
    assign host.fifo_count    = count;
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: 8N1, even-parity and depth-2
// instances at 16 clocks per bit, each test a task with inline checks.
module tb_uart_rx_oversampled;
    logic tb_clk = 1'b0;
    logic rst    = 1'b1;
    logic enable = 1'b1;
    logic rx_n   = 1'b1;
    logic rx_p   = 1'b1;
    logic rx_f   = 1'b1;

    int errors = 0;
    int checks = 0;

    always #5 tb_clk = ~tb_clk;

    uart_rx_oversampled_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_n ();
    uart_rx_oversampled_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_p ();
    uart_rx_oversampled_if #(.DATA_BITS(8), .FIFO_DEPTH(2)) if_f ();

    uart_rx_oversampled #(
        .CLOCK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_n (.clk(tb_clk), .Rst(rst), .enable(enable), .Rx(rx_n), .host(if_n));

    uart_rx_oversampled #(
        .CLOCK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_p (.clk(tb_clk), .Rst(rst), .enable(enable), .Rx(rx_p), .host(if_p));

    uart_rx_oversampled #(
        .CLOCK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(2)
    ) dut_f (.clk(tb_clk), .Rst(rst), .enable(enable), .Rx(rx_f), .host(if_f));

    task automatic set_rx(input int unsigned sel, input logic v);
        case (sel)
            0:       rx_n = v;
            1:       rx_p = v;
            default: rx_f = v;
        endcase
    endtask

    task automatic hold_bit(input int unsigned sel, input logic v);
        set_rx(sel, v);
        repeat (16) @(posedge tb_clk);
        #1;
    endtask

    task automatic send_frame(input int unsigned sel, input logic [7:0] d,
                              input bit has_par, input logic par, input logic stop_v);
        logic [7:0] sh;
        sh = d;
        hold_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) begin
            hold_bit(sel, sh[0]);
            sh = sh >> 1;
        end
        if (has_par) hold_bit(sel, par);
        hold_bit(sel, stop_v);
        set_rx(sel, 1'b1);
        repeat (4) @(posedge tb_clk);
        #1;
    endtask

    task automatic ack_n();
        if_n.data_ack = 1'b1;
        @(posedge tb_clk); #1;
        if_n.data_ack = 1'b0;
    endtask

    task automatic ack_p();
        if_p.data_ack = 1'b1;
        @(posedge tb_clk); #1;
        if_p.data_ack = 1'b0;
    endtask

    task automatic ack_f();
        if_f.data_ack = 1'b1;
        @(posedge tb_clk); #1;
        if_f.data_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge tb_clk);
        #1;
        rst = 1'b0;
        @(posedge tb_clk); #1;
        checks++; if (if_n.data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got=%h exp=00", if_n.data_out); end
        checks++; if (if_n.parity_error !== 1'b0) begin errors++; $display("FAIL reset_parity_error got=%b exp=0", if_n.parity_error); end
        checks++; if (if_n.framing_error !== 1'b0) begin errors++; $display("FAIL reset_framing_error got=%b exp=0", if_n.framing_error); end
        checks++; if (if_n.data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid got=%b exp=0", if_n.data_valid); end
        checks++; if (if_n.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", if_n.overrun); end
        checks++; if (if_n.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", if_n.busy); end
        checks++; if (if_n.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_fifo_count got=%0d exp=0", if_n.fifo_count); end
        checks++; if (if_f.fifo_count !== 2'd0 || if_p.busy !== 1'b0) begin
            errors++; $display("FAIL reset_other_duts got count=%0d busy=%b exp=0/0", if_f.fifo_count, if_p.busy);
        end
    endtask

    task automatic test_8n1();
        int cycles;
        cycles = 0;
        fork
            send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
            begin
                while (if_n.data_valid !== 1'b1 && cycles < 400) begin
                    @(posedge tb_clk); #1;
                    cycles++;
                end
            end
        join
        // 3 clocks to edge detect + 9*16+9 to the stop decision = 156
        checks++; if (cycles < 153 || cycles > 165) begin errors++; $display("FAIL latency_8n1 got=%0d exp=153..165", cycles); end
        checks++; if (if_n.data_out !== 8'hA5) begin errors++; $display("FAIL data_8n1 got=%h exp=a5", if_n.data_out); end
        checks++; if (if_n.parity_error !== 1'b0 || if_n.framing_error !== 1'b0) begin
            errors++; $display("FAIL flags_8n1 got pe=%b fe=%b exp=0/0", if_n.parity_error, if_n.framing_error);
        end
        ack_n();
        checks++; if (if_n.data_valid !== 1'b0 || if_n.fifo_count !== 3'd0) begin
            errors++; $display("FAIL ack_8n1 got valid=%b count=%0d exp=0/0", if_n.data_valid, if_n.fifo_count);
        end
    endtask

    task automatic test_parity();
        send_frame(1, 8'h53, 1'b1, 1'b1, 1'b1);
        checks++; if (if_p.data_out !== 8'h53) begin errors++; $display("FAIL parity_bad_data got=%h exp=53", if_p.data_out); end
        checks++; if (if_p.parity_error !== 1'b1) begin errors++; $display("FAIL parity_bad_flag got=%b exp=1", if_p.parity_error); end
        checks++; if (if_p.framing_error !== 1'b0) begin errors++; $display("FAIL parity_bad_ferr got=%b exp=0", if_p.framing_error); end
        ack_p();
        send_frame(1, 8'h53, 1'b1, 1'b0, 1'b1);
        checks++; if (if_p.data_out !== 8'h53 || if_p.parity_error !== 1'b0) begin
            errors++; $display("FAIL parity_good got data=%h pe=%b exp=53/0", if_p.data_out, if_p.parity_error);
        end
        ack_p();
    endtask

    task automatic test_framing();
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        checks++; if (if_n.data_out !== 8'h3C) begin errors++; $display("FAIL framing_data got=%h exp=3c", if_n.data_out); end
        checks++; if (if_n.framing_error !== 1'b1) begin errors++; $display("FAIL framing_flag got=%b exp=1", if_n.framing_error); end
        ack_n();
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        checks++; if (if_n.data_out !== 8'h81 || if_n.framing_error !== 1'b0 || if_n.fifo_count !== 3'd1) begin
            errors++; $display("FAIL framing_recover got data=%h fe=%b count=%0d exp=81/0/1",
                               if_n.data_out, if_n.framing_error, if_n.fifo_count);
        end
        ack_n();
    endtask

    task automatic test_false_start();
        bit saw_busy;
        saw_busy = 1'b0;
        rx_n = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == 5) rx_n = 1'b1;
            @(posedge tb_clk); #1;
            if (if_n.busy === 1'b1) saw_busy = 1'b1;
        end
        checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL false_start_busy_pulse got=%b exp=1", saw_busy); end
        checks++; if (if_n.busy !== 1'b0) begin errors++; $display("FAIL false_start_busy_end got=%b exp=0", if_n.busy); end
        checks++; if (if_n.fifo_count !== 3'd0 || if_n.data_valid !== 1'b0) begin
            errors++; $display("FAIL false_start_push got count=%0d valid=%b exp=0/0", if_n.fifo_count, if_n.data_valid);
        end
    endtask

    task automatic test_overrun();
        send_frame(2, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(2, 8'h22, 1'b0, 1'b0, 1'b1);
        send_frame(2, 8'h33, 1'b0, 1'b0, 1'b1);
        checks++; if (if_f.fifo_count !== 2'd2) begin errors++; $display("FAIL overrun_count got=%0d exp=2", if_f.fifo_count); end
        checks++; if (if_f.overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got=%b exp=1", if_f.overrun); end
        checks++; if (if_f.data_out !== 8'h11) begin errors++; $display("FAIL overrun_head got=%h exp=11", if_f.data_out); end
        ack_f();
        checks++; if (if_f.data_out !== 8'h22 || if_f.overrun !== 1'b0 || if_f.fifo_count !== 2'd1) begin
            errors++; $display("FAIL overrun_after_ack got data=%h ovr=%b count=%0d exp=22/0/1",
                               if_f.data_out, if_f.overrun, if_f.fifo_count);
        end
        rx_f = 1'b0;
        repeat (40) @(posedge tb_clk);
        #1;
        checks++; if (if_f.busy !== 1'b1) begin errors++; $display("FAIL midframe_busy got=%b exp=1", if_f.busy); end
        rst = 1'b1;
        @(posedge tb_clk); #1;
        checks++; if (if_f.fifo_count !== 2'd0 || if_f.busy !== 1'b0 || if_f.data_valid !== 1'b0) begin
            errors++; $display("FAIL midframe_reset got count=%0d busy=%b valid=%b exp=0/0/0",
                               if_f.fifo_count, if_f.busy, if_f.data_valid);
        end
        rx_f = 1'b1;
        @(posedge tb_clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        if_n.data_ack = 1'b0;
        if_p.data_ack = 1'b0;
        if_f.data_ack = 1'b0;
        test_reset();
        test_8n1();
        test_parity();
        test_framing();
        test_false_start();
        test_overrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
